// File: rtl/reg_file_pkg.sv
// Shared constants for the multi-port register file.
// Default geometry and read-mode encodings.
package reg_file_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int NUM_RD_DEF = 2;

  localparam int RD_COMB = 0;
  localparam int RD_REG  = 1;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits: clear on write, set on issue (set wins).
// Ports: CLK, RESET, clr/set enables+addresses, rd_addr in, busy_rd out.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        busy_rd
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy;
  logic             set_ok;

  assign set_ok = set_en &&
                  !((ZERO_REG != 0) && (set_addr == '0));

  // Set is applied after clear so a same-edge issue keeps the bit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_ok) busy[set_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign busy_rd[k] = busy[rd_addr[k*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with bypass, zero register and busy tracking.
// Ports: CLK, RESET, WRITE/INADDRESS/IN, RDADDR->OUT, BUSY_SET/BUSY_ADDR, BUSY.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int REG_READ = RD_COMB,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     WRITE,
  input  logic [ADDR_W-1:0]        INADDRESS,
  input  logic [DATA_W-1:0]        IN,
  input  logic [NUM_RD*ADDR_W-1:0] RDADDR,
  output logic [NUM_RD*DATA_W-1:0] OUT,
  input  logic                     BUSY_SET,
  input  logic [ADDR_W-1:0]        BUSY_ADDR,
  output logic [NUM_RD-1:0]        BUSY
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem [DEPTH];
  logic                     write_ok;
  logic [NUM_RD*DATA_W-1:0] rd_flat;

  assign write_ok = WRITE &&
                    !((ZERO_REG != 0) && (INADDRESS == '0));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (write_ok) begin
      mem[INADDRESS] <= IN;
    end
  end

  // Word selected for each port before the optional output register.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero;
    logic              hit;
    assign ra      = RDADDR[k*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (ra == '0);
    assign hit     = (BYPASS != 0) && write_ok &&
                     (INADDRESS == ra);
    assign rd_flat[k*DATA_W +: DATA_W] =
      is_zero ? '0 :
      hit     ? IN : mem[ra];
  end

  if (REG_READ == RD_REG) begin : g_reg
    logic [NUM_RD*DATA_W-1:0] out_q;
    always_ff @(posedge CLK) begin
      if (RESET) out_q <= '0;
      else       out_q <= rd_flat;
    end
    assign OUT = out_q;
  end else begin : g_comb
    assign OUT = rd_flat;
  end

  reg_file_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .CLK      (CLK),
    .RESET    (RESET),
    .clr_en   (write_ok),
    .clr_addr (INADDRESS),
    .set_en   (BUSY_SET),
    .set_addr (BUSY_ADDR),
    .rd_addr  (RDADDR),
    .busy_rd  (BUSY)
  );

endmodule
